mem_wb: RTL and testbench

Memory-access and write-back stage of the three-stage RISC-V core, directly downstream of `execute`. It takes one executed instruction per handshake and issues the data-memory load or store with byte lanes aligned. It extracts and sign/zero-extends load data and drives the register-file write port. It also decodes the two MMIO addresses (console `putc`, simulation `exit`) and stalls `execute` while a memory access is outstanding.

---
 rtl/mem_wb_pkg.sv | 25 ++
 rtl/load_aligner.sv | 33 +++
 rtl/mem_wb.sv | 166 ++++++++++++++++
 tb/tb_mem_wb.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// Shared definitions for the memory-access / write-back stage:
// access sizes, MMIO addresses, FSM states and the alignment rule.
package mem_wb_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [31:0] MMIO_PUTC_ADDR = 32'h8000_001c;
  localparam logic [31:0] MMIO_EXIT_ADDR = 32'h8000_002c;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } state_t;

  // Size 2'b11 is handled as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    if (size == SZ_B) return 1'b0;
    if (size == SZ_H) return lo[0];
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/load_aligner.sv
// Picks the addressed byte/half out of a load word and sign- or zero-extends it.
module load_aligner
  import mem_wb_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    unique case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    value = rdata;
    if (size == SZ_B)
      value = {{24{~load_unsigned & byte_sel[7]}}, byte_sel};
    else if (size == SZ_H)
      value = {{16{~load_unsigned & half_sel[15]}}, half_sel};
  end

endmodule

// File: rtl/mem_wb.sv
// Memory-access and write-back stage: issues aligned dmem requests, extends
// load data, drives the register-file write port and decodes the MMIO ports.
//   state   | meaning
//   ST_IDLE | ready for the next instruction from execute
//   ST_REQ  | dmem request held until dmem_ready
//   ST_WAIT | load issued; capture rvalid data, then write back
module mem_wb
  import mem_wb_pkg::*;
#(
  parameter logic [31:0] PUTC_ADDR = MMIO_PUTC_ADDR,
  parameter logic [31:0] EXIT_ADDR = MMIO_EXIT_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_store_data,
  input  logic        ex_mem_write,
  input  logic        ex_mem_to_reg,
  input  logic [1:0]  ex_mem_size,
  input  logic        ex_load_unsigned,
  input  logic [4:0]  ex_dest_reg,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [29:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wbe,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        misaligned,
  output logic        putc_valid,
  output logic [7:0]  putc_char,
  output logic        exit
);

  state_t      state_q, state_d;
  logic        load_done_q;
  logic [31:0] req_addr_q;
  logic        req_we_q;
  logic [31:0] req_wdata_q;
  logic [3:0]  req_wbe_q;
  logic [4:0]  req_rd_q;
  logic [1:0]  req_size_q;
  logic        req_unsigned_q;

  logic        accept, is_mem, is_mis, is_putc, is_exit;
  logic [31:0] st_wdata;
  logic [3:0]  st_wbe;
  logic [31:0] load_value;

  assign ex_ready   = (state_q == ST_IDLE);
  assign dmem_req   = (state_q == ST_REQ);
  assign dmem_we    = req_we_q;
  assign dmem_addr  = req_addr_q[31:2];
  assign dmem_wdata = req_wdata_q;
  assign dmem_wbe   = req_wbe_q;

  assign accept  = ex_valid & ex_ready;
  assign is_mem  = ex_mem_write | ex_mem_to_reg;
  assign is_mis  = is_mem & is_misaligned(ex_mem_size, ex_result[1:0]);
  assign is_putc = ex_mem_write & ~is_mis & (ex_result == PUTC_ADDR);
  assign is_exit = ex_mem_write & ~is_mis & (ex_result == EXIT_ADDR);

  always_comb begin
    st_wdata = ex_store_data;
    st_wbe   = 4'b1111;
    case (ex_mem_size)
      SZ_B: begin
        st_wdata = {4{ex_store_data[7:0]}};
        st_wbe   = 4'b0001 << ex_result[1:0];
      end
      SZ_H: begin
        st_wdata = {2{ex_store_data[15:0]}};
        st_wbe   = 4'b0011 << ex_result[1:0];
      end
      default: ;
    endcase
    if (!ex_mem_write) st_wbe = 4'b0000;
  end

  load_aligner u_load_aligner (
    .rdata         (dmem_rdata),
    .addr          (req_addr_q[1:0]),
    .size          (req_size_q),
    .load_unsigned (req_unsigned_q),
    .value         (load_value)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept && is_mem && !is_mis && !is_putc && !is_exit) state_d = ST_REQ;
      ST_REQ:  if (dmem_ready) state_d = req_we_q ? ST_IDLE : ST_WAIT;
      ST_WAIT: if (load_done_q) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_done_q    <= 1'b0;
      req_addr_q     <= '0;
      req_we_q       <= 1'b0;
      req_wdata_q    <= '0;
      req_wbe_q      <= '0;
      req_rd_q       <= '0;
      req_size_q     <= '0;
      req_unsigned_q <= 1'b0;
      wb_en          <= 1'b0;
      wb_reg         <= '0;
      wb_data        <= '0;
      misaligned     <= 1'b0;
      putc_valid     <= 1'b0;
      putc_char      <= '0;
      exit           <= 1'b0;
    end else begin
      wb_en       <= 1'b0;
      misaligned  <= 1'b0;
      putc_valid  <= 1'b0;
      load_done_q <= 1'b0;
      if (accept) begin
        if (!is_mem) begin
          wb_en   <= (ex_dest_reg != 5'd0);
          wb_reg  <= ex_dest_reg;
          wb_data <= ex_result;
        end else if (is_mis) begin
          misaligned <= 1'b1;
        end else if (is_putc) begin
          putc_valid <= 1'b1;
          putc_char  <= ex_store_data[7:0];
        end else if (is_exit) begin
          exit <= 1'b1;
        end else begin
          req_addr_q     <= ex_result;
          req_we_q       <= ex_mem_write;
          req_wdata_q    <= st_wdata;
          req_wbe_q      <= st_wbe;
          req_rd_q       <= ex_dest_reg;
          req_size_q     <= ex_mem_size;
          req_unsigned_q <= ex_load_unsigned;
        end
      end
      // Load data lands in wb_data one cycle ahead of the write strobe.
      if (state_q == ST_WAIT) begin
        if (load_done_q) begin
          wb_en  <= (req_rd_q != 5'd0);
          wb_reg <= req_rd_q;
        end else if (dmem_rvalid) begin
          wb_data     <= load_value;
          load_done_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_wb.sv
// Bench for mem_wb: directed timing cases plus random instruction traffic
// checked against a byte-level memory and instruction-semantics model.
module tb_mem_wb;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_result, ex_store_data;
  logic        ex_mem_write, ex_mem_to_reg, ex_load_unsigned;
  logic [1:0]  ex_mem_size;
  logic [4:0]  ex_dest_reg;
  logic        dmem_req, dmem_we, dmem_ready, dmem_rvalid;
  logic [29:0] dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wbe;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        misaligned, putc_valid, exit_flag;
  logic [7:0]  putc_char;

  always #5 clk = ~clk;

  mem_wb dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_result(ex_result), .ex_store_data(ex_store_data),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_size(ex_mem_size), .ex_load_unsigned(ex_load_unsigned),
    .ex_dest_reg(ex_dest_reg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wbe(dmem_wbe), .dmem_ready(dmem_ready),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .misaligned(misaligned), .putc_valid(putc_valid), .putc_char(putc_char),
    .exit(exit_flag)
  );

  typedef struct {logic [4:0] rd; logic [31:0] data;} wb_t;
  typedef struct {logic we; logic [29:0] addr; logic [3:0] wbe; logic [31:0] wdata;} txn_t;

  wb_t        wb_q[$];
  txn_t       txn_q[$];
  logic [7:0] putc_q[$];
  logic [7:0] ref_mem [64];
  logic [31:0] ram [16];
  int   checks = 0, errors = 0;
  int   misal_exp = 0, misal_seen = 0;
  logic exit_exp = 1'b0;
  int   mem_mode = 1;
  logic rd_pending = 1'b0;
  logic [3:0] rd_idx = '0;
  wb_t  mon_w;
  txn_t mon_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preset_word(input int idx, input logic [31:0] val);
    ram[idx] = val;
    for (int k = 0; k < 4; k++) ref_mem[4*idx+k] = val[8*k +: 8];
  endtask

  // Memory side: 0 random, 1 zero-wait, 2 stalled, 3 ready but no rvalid, 4 stray rvalid
  always @(negedge clk) begin
    case (mem_mode)
      0: begin
        dmem_ready  = dmem_req && ($urandom_range(0, 2) == 0);
        dmem_rvalid = rd_pending && ($urandom_range(0, 1) == 0);
      end
      1: begin dmem_ready = dmem_req; dmem_rvalid = rd_pending; end
      2: begin dmem_ready = 1'b0; dmem_rvalid = 1'b0; end
      3: begin dmem_ready = dmem_req; dmem_rvalid = 1'b0; end
      default: begin dmem_ready = 1'b0; dmem_rvalid = 1'b1; end
    endcase
    dmem_rdata = rd_pending ? ram[rd_idx] : $urandom();
  end

  always @(posedge clk) begin
    if (reset && dmem_req && dmem_ready) begin
      if (txn_q.size() == 0) chk("dmem_unexpected", 32'(dmem_req), 32'd0);
      else begin
        mon_t = txn_q.pop_front();
        chk("dmem_we", 32'(dmem_we), 32'(mon_t.we));
        chk("dmem_addr", 32'(dmem_addr), 32'(mon_t.addr));
        chk("dmem_wbe", 32'(dmem_wbe), 32'(mon_t.wbe));
        if (mon_t.we) chk("dmem_wdata", dmem_wdata, mon_t.wdata);
      end
      if (dmem_we) begin
        for (int j = 0; j < 4; j++)
          if (dmem_wbe[j]) ram[dmem_addr[3:0]][8*j +: 8] = dmem_wdata[8*j +: 8];
      end else begin
        rd_pending = 1'b1;
        rd_idx = dmem_addr[3:0];
      end
    end else if (rd_pending && dmem_rvalid) begin
      rd_pending = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (wb_en) begin
        if (wb_q.size() == 0) chk("wb_spurious", 32'(wb_en), 32'd0);
        else begin
          mon_w = wb_q.pop_front();
          chk("wb_reg", 32'(wb_reg), 32'(mon_w.rd));
          chk("wb_data", wb_data, mon_w.data);
        end
      end
      if (misaligned) misal_seen++;
      if (putc_valid) begin
        if (putc_q.size() == 0) chk("putc_spurious", 32'(putc_valid), 32'd0);
        else chk("putc_char", 32'(putc_char), 32'(putc_q.pop_front()));
      end
      chk("exit", 32'(exit_flag), 32'(exit_exp));
    end
  end

  // Expected effects of one accepted instruction, from the ISA semantics.
  task automatic model(input logic st, input logic ld, input logic [31:0] res,
                       input logic [31:0] sd, input logic [1:0] sz, input logic uns,
                       input logic [4:0] rd);
    int n, base;
    logic [31:0] v, wd;
    logic [3:0] be;
    wb_t w;
    txn_t t;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    base = int'(res & 32'h3f);
    if (!st && !ld) begin
      if (rd != 0) begin w.rd = rd; w.data = res; wb_q.push_back(w); end
    end else if ((res % n) != 0) begin
      misal_exp++;
    end else if (st && res == 32'h8000_001c) begin
      putc_q.push_back(sd[7:0]);
    end else if (st && res == 32'h8000_002c) begin
      exit_exp = 1'b1;
    end else if (st) begin
      be = '0;
      for (int k = 0; k < n; k++) begin
        be[(base % 4) + k] = 1'b1;
        ref_mem[(base + k) % 64] = sd[8*k +: 8];
      end
      for (int j = 0; j < 4; j++) wd[8*j +: 8] = sd[8*(j % n) +: 8];
      t.we = 1'b1; t.addr = res[31:2]; t.wbe = be; t.wdata = wd;
      txn_q.push_back(t);
    end else begin
      v = '0;
      for (int k = 0; k < n; k++) v = v | (32'(ref_mem[(base + k) % 64]) << (8*k));
      if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      t.we = 1'b0; t.addr = res[31:2]; t.wbe = 4'b0000; t.wdata = '0;
      txn_q.push_back(t);
      if (rd != 0) begin w.rd = rd; w.data = v; wb_q.push_back(w); end
    end
  endtask

  task automatic issue(input logic st, input logic ld, input logic [31:0] res,
                       input logic [31:0] sd, input logic [1:0] sz, input logic uns,
                       input logic [4:0] rd);
    int waited;
    waited = 0;
    ex_valid = 1'b1; ex_mem_write = st; ex_mem_to_reg = ld; ex_result = res;
    ex_store_data = sd; ex_mem_size = sz; ex_load_unsigned = uns; ex_dest_reg = rd;
    @(negedge clk);
    while (!ex_ready && waited < 200) begin @(negedge clk); waited++; end
    if (!ex_ready) begin
      chk("accept_timeout", 32'(ex_ready), 32'd1);
      ex_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    ex_valid = 1'b0;
    model(st, ld, res, sd, sz, uns, rd);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input string tag);
    int waited;
    waited = 0;
    while (!ex_ready && waited < 100) begin step(); waited++; end
    chk(tag, 32'(ex_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, drain;
    logic [31:0] a;
    ex_valid = 0; ex_result = 0; ex_store_data = 0; ex_mem_write = 0;
    ex_mem_to_reg = 0; ex_mem_size = 0; ex_load_unsigned = 0; ex_dest_reg = 0;
    dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = 0;
    for (int i = 0; i < 16; i++) preset_word(i, $urandom());

    repeat (3) step();
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_exit", 32'(exit_flag), 32'd0);
    chk("rst_outputs", {misaligned, putc_valid, dmem_wbe}, 32'd0);
    reset = 1'b1;
    step();

    issue(0, 0, 32'h1234, 0, 2'b00, 0, 5'd5);
    chk("alu_wb_en", 32'(wb_en), 32'd1);
    chk("alu_wb_reg", 32'(wb_reg), 32'd5);
    chk("alu_wb_data", wb_data, 32'h1234);
    step();
    chk("alu_pulse", 32'(wb_en), 32'd0);
    issue(0, 0, 32'h5678, 0, 2'b00, 0, 5'd0);
    chk("alu_rd0", 32'(wb_en), 32'd0);

    mem_mode = 2;
    issue(1, 0, 32'h102, 32'hAB, 2'b00, 0, 5'd1);
    for (int i = 0; i < 3; i++) begin
      chk("sb_req", 32'(dmem_req), 32'd1);
      chk("sb_ex_ready", 32'(ex_ready), 32'd0);
      chk("sb_wbe", 32'(dmem_wbe), 32'h4);
      chk("sb_wdata", dmem_wdata, 32'hABABABAB);
      chk("sb_addr", 32'(dmem_addr), 32'h40);
      step();
    end
    mem_mode = 1;
    wait_ready("sb_done");

    preset_word(0, 32'h8001_1234);
    issue(0, 1, 32'h202, 0, 2'b01, 0, 5'd9);
    step(); step();
    chk("lh_early", 32'(wb_en), 32'd0);
    step();
    chk("lh_wb_en", 32'(wb_en), 32'd1);
    chk("lh_wb_data", wb_data, 32'hFFFF8001);
    issue(0, 1, 32'h202, 0, 2'b01, 1, 5'd9);
    step(); step(); step();
    chk("lhu_wb_en", 32'(wb_en), 32'd1);
    chk("lhu_wb_data", wb_data, 32'h0000_8001);

    issue(0, 1, 32'h103, 0, 2'b10, 0, 5'd4);
    chk("lw_mis_pulse", 32'(misaligned), 32'd1);
    chk("lw_mis_req", 32'(dmem_req), 32'd0);
    chk("lw_mis_ready", 32'(ex_ready), 32'd1);
    chk("lw_mis_wb", 32'(wb_en), 32'd0);

    issue(1, 0, 32'h8000_001c, 32'h41, 2'b10, 0, 5'd0);
    chk("putc_valid", 32'(putc_valid), 32'd1);
    chk("putc_char_dir", 32'(putc_char), 32'h41);
    chk("putc_req", 32'(dmem_req), 32'd0);
    issue(1, 0, 32'h8000_002c, 32'h0, 2'b10, 0, 5'd0);
    chk("exit_set", 32'(exit_flag), 32'd1);
    chk("exit_req", 32'(dmem_req), 32'd0);
    repeat (3) step();
    chk("exit_sticky", 32'(exit_flag), 32'd1);

    mem_mode = 0;
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 9);
      a = 32'h100 | 32'($urandom_range(0, 63));
      if (kind <= 2)
        issue(0, 0, $urandom(), $urandom(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      else if (kind <= 5)
        issue(0, 1, a, $urandom(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      else if (kind <= 8)
        issue(1, 0, a, $urandom(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      else
        issue(1, 0, ($urandom_range(0, 3) == 0) ? 32'h8000_002c : 32'h8000_001c, $urandom(),
              2'($urandom_range(0, 3)), 0, 5'($urandom_range(0, 31)));
    end
    drain = 0;
    while ((wb_q.size() != 0 || txn_q.size() != 0 || !ex_ready) && drain < 300) begin step(); drain++; end
    step();
    chk("wb_drain", 32'(wb_q.size()), 32'd0);
    chk("txn_drain", 32'(txn_q.size()), 32'd0);
    chk("putc_drain", 32'(putc_q.size()), 32'd0);
    chk("misaligned_count", 32'(misal_seen), 32'(misal_exp));

    mem_mode = 3;
    issue(0, 1, 32'h104, 0, 2'b10, 0, 5'd7);
    step(); step();
    reset = 1'b0;
    wb_q.delete(); txn_q.delete(); exit_exp = 1'b0;
    #1;
    chk("rst_wait_req", 32'(dmem_req), 32'd0);
    chk("rst_wait_exit", 32'(exit_flag), 32'd0);
    step();
    reset = 1'b1;
    mem_mode = 4;
    chk("rst_wait_ready", 32'(ex_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("late_rvalid_wb", 32'(wb_en), 32'd0);
      chk("late_rvalid_req", 32'(dmem_req), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
